// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: reset vector, NOP encoding, fetch FSM states
// and the decode bundle layout.
package cpu_pkg;
  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FS_REQ   = 2'd0,
    FS_VALID = 2'd1,
    FS_ERR   = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } id_bundle_t;
endpackage

// File: rtl/add4.sv
// PC incrementer: y = a + 4, wrapping modulo 2^32.
module add4 (
  input  logic [31:0] a,
  output logic [31:0] y
);
  assign y = a + 32'd4;
endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch stage: one outstanding request, single-entry decode bundle,
// redirect squashing and a sticky misaligned-target error state.
module pc_fetch import cpu_pkg::*; #(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic [31:0] id_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_misalign
);
  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  logic         req_q, req_d;
  logic         squash_q, squash_d;
  logic         misalign_q, misalign_d;
  logic         valid_q, valid_d;
  id_bundle_t   bundle_q, bundle_d;
  logic [31:0]  pc4;
  logic         fire;

  add4 u_add4 (.a(pc_q), .y(pc4));

  assign fire = req_q & imem_ack;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    req_d      = req_q;
    squash_d   = squash_q;
    misalign_d = misalign_q;
    valid_d    = valid_q;
    bundle_d   = bundle_q;
    if (redirect_valid) begin
      valid_d = 1'b0;
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_d = 1'b1;
        state_d    = FS_ERR;
      end else begin
        misalign_d = 1'b0;
        state_d    = FS_REQ;
        pc_d       = redirect_pc;
      end
      // An un-acked request must stay on the bus; its data is squashed later.
      if (req_q && !imem_ack) begin
        squash_d = 1'b1;
      end else begin
        squash_d = 1'b0;
        req_d    = (redirect_pc[1:0] == 2'b00);
        addr_d   = redirect_pc;
      end
    end else begin
      unique case (state_q)
        FS_REQ: begin
          if (fire) begin
            if (squash_q) begin
              squash_d = 1'b0;
              addr_d   = pc_q;
            end else begin
              bundle_d = '{pc: pc_q, pc4: pc4, instr: imem_rdata};
              pc_d     = pc4;
              valid_d  = 1'b1;
              req_d    = 1'b0;
              state_d  = FS_VALID;
            end
          end else if (!req_q) begin
            req_d  = 1'b1;
            addr_d = pc_q;
          end
        end
        FS_VALID: begin
          if (id_ready) begin
            valid_d = 1'b0;
            req_d   = 1'b1;
            addr_d  = pc_q;
            state_d = FS_REQ;
          end
        end
        FS_ERR: begin
          if (fire) begin
            req_d    = 1'b0;
            squash_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FS_REQ;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
      squash_q   <= 1'b0;
      misalign_q <= 1'b0;
      valid_q    <= 1'b0;
      bundle_q   <= '{pc: 32'h0, pc4: 32'h0, instr: NOP_INSTR};
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      squash_q   <= squash_d;
      misalign_q <= misalign_d;
      valid_q    <= valid_d;
      bundle_q   <= bundle_d;
    end
  end

  assign imem_req       = req_q;
  assign imem_addr      = addr_q;
  assign id_valid       = valid_q;
  assign id_pc          = bundle_q.pc;
  assign id_pc4         = bundle_q.pc4;
  assign id_instr       = valid_q ? bundle_q.instr : NOP_INSTR;
  assign fetch_misalign = misalign_q;
endmodule
